// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM and MEM/WB registers, data-memory handshake,
// store lane replication, load alignment/extension and misaligned-access traps.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [XLEN-1:0]   i_ex_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [4:0]        i_dest_addr,
    input  logic              i_reg_write_en,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_mem_size,
    input  logic              i_mem_unsigned,
    output logic              o_stall,
    output logic [XLEN-1:0]   o_ex_mem_data,
    output logic [4:0]        o_ex_mem_dest_addr,
    output logic              o_ex_mem_reg_write_en,
    output logic [XLEN-1:0]   o_mem_wb_data,
    output logic [4:0]        o_mem_wb_dest_addr,
    output logic              o_mem_wb_reg_write_en,
    output logic              o_wb_valid,
    output logic              o_wb_trap,
    output logic              o_dmem_req,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic              o_dmem_wen,
    output logic [XLEN-1:0]   o_dmem_wdata,
    output logic [3:0]        o_dmem_mask,
    input  logic              i_dmem_ready,
    input  logic              i_dmem_rvalid,
    input  logic [XLEN-1:0]   i_dmem_rdata
);
    localparam int LANES = XLEN / 8;

    typedef enum logic {IDLE, WAIT_RESP} state_t;
    state_t r_state, w_state_next;

    logic            r_exm_valid;
    logic [XLEN-1:0] r_exm_data;
    logic [XLEN-1:0] r_exm_rs2;
    logic [4:0]      r_exm_rd;
    logic            r_exm_we;
    logic            r_exm_ld;
    logic            r_exm_st;
    logic [1:0]      r_exm_size;
    logic            r_exm_uns;

    logic            r_wb_valid;
    logic [XLEN-1:0] r_wb_data;
    logic [4:0]      r_wb_rd;
    logic            r_wb_we;
    logic            r_wb_trap;

    logic            w_is_mem;
    logic            w_misaligned;
    logic            w_mem_go;
    logic            w_req;
    logic            w_complete;
    logic            w_stall;
    logic            w_retire;
    logic [LANES-1:0] w_byte_mask;
    logic [3:0]      w_mask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_shifted;
    logic            w_ld_sign;
    logic [XLEN-1:0] w_load_data;

    assign w_is_mem     = r_exm_ld | r_exm_st;
    // Size 3 is treated like a word access.
    assign w_misaligned = w_is_mem &
                          (((r_exm_size == 2'd1) & r_exm_data[0]) |
                           (r_exm_size[1] & (|r_exm_data[1:0])));
    assign w_mem_go     = r_exm_valid & w_is_mem & ~w_misaligned;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_go) begin
                    w_req = 1'b1;
                    if (i_dmem_ready) begin
                        if (r_exm_st) begin
                            w_complete = 1'b1;
                        end else if (i_dmem_rvalid) begin
                            w_complete = 1'b1;
                        end else begin
                            w_state_next = WAIT_RESP;
                        end
                    end
                end
            end
            WAIT_RESP: begin
                if (i_dmem_rvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_stall  = w_mem_go & ~w_complete;
    assign w_retire = r_exm_valid & ~w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_byte_mask[gi] = (r_exm_data[1:0] == 2'(gi));
        end
    endgenerate

    always_comb begin
        w_mask  = 4'b1111;
        w_wdata = r_exm_rs2;
        case (r_exm_size)
            2'd0: begin
                w_mask  = w_byte_mask;
                w_wdata = {4{r_exm_rs2[7:0]}};
            end
            2'd1: begin
                w_mask  = r_exm_data[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_exm_rs2[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = r_exm_rs2;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend from the access width.
    assign w_shifted = i_dmem_rdata >> {r_exm_data[1:0], 3'b000};
    assign w_ld_sign = ~r_exm_uns & ((r_exm_size == 2'd0) ? w_shifted[7] : w_shifted[15]);

    always_comb begin
        w_load_data = w_shifted;
        case (r_exm_size)
            2'd0:    w_load_data = {{24{w_ld_sign}}, w_shifted[7:0]};
            2'd1:    w_load_data = {{16{w_ld_sign}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_exm_valid <= 1'b0;
            r_exm_data  <= '0;
            r_exm_rs2   <= '0;
            r_exm_rd    <= '0;
            r_exm_we    <= 1'b0;
            r_exm_ld    <= 1'b0;
            r_exm_st    <= 1'b0;
            r_exm_size  <= '0;
            r_exm_uns   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_wb_we     <= 1'b0;
            r_wb_trap   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (!w_stall) begin
                r_exm_valid <= i_valid;
                r_exm_data  <= i_ex_data;
                r_exm_rs2   <= i_rs2_data;
                r_exm_rd    <= i_dest_addr;
                r_exm_we    <= i_reg_write_en;
                r_exm_ld    <= i_mem_read;
                r_exm_st    <= i_mem_write;
                r_exm_size  <= i_mem_size;
                r_exm_uns   <= i_mem_unsigned;
            end
            if (w_retire) begin
                r_wb_valid <= 1'b1;
                r_wb_data  <= (r_exm_ld & ~r_exm_st & ~w_misaligned) ? w_load_data : r_exm_data;
                r_wb_rd    <= r_exm_rd;
                r_wb_we    <= r_exm_we & ~w_misaligned;
                r_wb_trap  <= w_misaligned;
            end else begin
                r_wb_valid <= 1'b0;
                r_wb_we    <= 1'b0;
                r_wb_trap  <= 1'b0;
            end
        end
    end

    assign o_stall               = w_stall;
    assign o_ex_mem_data         = r_exm_data;
    assign o_ex_mem_dest_addr    = r_exm_rd;
    assign o_ex_mem_reg_write_en = r_exm_valid & r_exm_we & ~r_exm_ld & ~w_misaligned;
    assign o_mem_wb_data         = r_wb_data;
    assign o_mem_wb_dest_addr    = r_wb_rd;
    assign o_mem_wb_reg_write_en = r_wb_we;
    assign o_wb_valid            = r_wb_valid;
    assign o_wb_trap             = r_wb_trap;

    // Bus fields are quiet whenever no request is being presented.
    assign o_dmem_req   = w_req;
    assign o_dmem_addr  = w_req ? {r_exm_data[XLEN-1:2], 2'b00} : '0;
    assign o_dmem_wen   = w_req & r_exm_st;
    assign o_dmem_wdata = w_req ? w_wdata : '0;
    assign o_dmem_mask  = w_req ? w_mask : 4'b0000;

endmodule
